// File: rtl/supernova_bpu_pkg.sv
// Shared types for the branch resolver and its prediction queue.
// No logic; record layouts are fixed at BPU_XLEN address bits.
// Used by supernova_pred_queue and supernova_branch_resolver.
package supernova_bpu_pkg;

  localparam int BPU_XLEN = 64;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rsv_state_e;

  typedef struct packed {
    logic [BPU_XLEN-1:0] pc;
    logic [BPU_XLEN-1:0] target;
    logic                taken;
  } pred_entry_t;

  typedef struct packed {
    logic [BPU_XLEN-1:0] pc;
    logic [BPU_XLEN-1:0] target;
    logic                taken;
    logic                is_call;
    logic                is_ret;
  } resolve_t;

  typedef struct packed {
    logic [BPU_XLEN-1:0] pc;
    logic [BPU_XLEN-1:0] target;
    logic                taken;
    logic                is_call;
    logic                is_ret;
    logic [BPU_XLEN-1:0] ret_addr;
  } bpu_update_t;

  // Fall-through PC of a 4-byte branch; wraps mod 2^BPU_XLEN.
  function automatic logic [BPU_XLEN-1:0] seq_npc(input logic [BPU_XLEN-1:0] pc);
    return pc + BPU_XLEN'(4);
  endfunction

endpackage

// File: rtl/supernova_pred_queue.sv
// In-order FIFO of fetch-time predictions with a single-cycle flush.
// Latency: a pushed record is visible at head the cycle after the push.
// Backpressure: push ignored when full or flushing; pop ignored when empty.
module supernova_pred_queue
  import supernova_bpu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  pred_entry_t              push_dat,
  input  logic                     pop,
  input  logic                     flush,
  output pred_entry_t              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  pred_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Occupancy comes from the count register so a full queue never looks empty.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Record storage; validity is tracked by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and count update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/supernova_branch_resolver.sv
// Checks queued predictions against in-order resolutions; drives predictor update and redirect.
// Latency: update/redirect strobes one cycle after the resolve fire.
// Backpressure: pred_ready low when full or flushing; res_ready low when empty or flushing.
module supernova_branch_resolver
  import supernova_bpu_pkg::*;
#(
  parameter int XLEN     = BPU_XLEN,
  parameter int PQ_DEPTH = 16,
  parameter int CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pred_valid,
  output logic                        pred_ready,
  input  logic [XLEN-1:0]             pred_pc,
  input  logic [XLEN-1:0]             pred_target,
  input  logic                        pred_taken,
  input  logic                        res_valid,
  output logic                        res_ready,
  input  logic [XLEN-1:0]             res_pc,
  input  logic [XLEN-1:0]             res_target,
  input  logic                        res_taken,
  input  logic                        res_is_call,
  input  logic                        res_is_ret,
  output logic                        update_en,
  output logic [XLEN-1:0]             update_pc,
  output logic [XLEN-1:0]             update_target,
  output logic                        update_taken,
  output logic                        is_call,
  output logic                        is_ret,
  output logic [XLEN-1:0]             ret_addr,
  output logic                        redirect_valid,
  output logic [XLEN-1:0]             redirect_pc,
  output logic [CNT_W-1:0]            mispredict_cnt,
  output logic [$clog2(PQ_DEPTH):0]   pq_count
);

  // XLEN must equal BPU_XLEN: the queued and update records are built at that width.
  rsv_state_e      state;
  pred_entry_t     head;
  pred_entry_t     push_dat;
  resolve_t        res;
  bpu_update_t     upd_q;
  logic            push;
  logic            fire;
  logic            mispredict;
  logic            pq_full;
  logic            pq_empty;
  logic [XLEN-1:0] actual_npc;

  assign push_dat = '{pc: pred_pc, target: pred_target, taken: pred_taken};
  assign res      = '{pc: res_pc, target: res_target, taken: res_taken,
                      is_call: res_is_call, is_ret: res_is_ret};

  assign pred_ready = (state == RUN) && !pq_full;
  assign res_ready  = (state == RUN) && !pq_empty;
  assign push       = pred_valid && pred_ready;
  assign fire       = res_valid && res_ready;

  // A PC mismatch means fetch and commit lost sync; treat it like any wrong guess.
  assign mispredict = fire && ((head.pc != res.pc) ||
                               (head.taken != res.taken) ||
                               (res.taken && (head.target != res.target)));
  assign actual_npc = res.taken ? res.target : seq_npc(res.pc);

  // Mispredict flushes the queue and drops any same-cycle push as wrong-path.
  supernova_pred_queue #(.DEPTH(PQ_DEPTH)) u_pq (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (fire),
    .flush    (mispredict),
    .head     (head),
    .count    (pq_count),
    .full     (pq_full),
    .empty    (pq_empty)
  );

  // RUN/FLUSH: one dead cycle after a mispredict while the front end redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (mispredict) state <= FLUSH;
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Update, redirect and counter registers; update fields hold until the next fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_en      <= 1'b0;
      upd_q          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
    end else begin
      update_en      <= fire;
      redirect_valid <= mispredict;
      if (fire) begin
        upd_q <= '{pc: res.pc, target: res.target, taken: res.taken,
                   is_call: res.is_call, is_ret: res.is_ret,
                   ret_addr: res.is_call ? seq_npc(res.pc) : '0};
      end
      if (mispredict) begin
        redirect_pc <= actual_npc;
        if (mispredict_cnt != '1) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
    end
  end

  assign update_pc     = upd_q.pc;
  assign update_target = upd_q.target;
  assign update_taken  = upd_q.taken;
  assign is_call       = upd_q.is_call;
  assign is_ret        = upd_q.is_ret;
  assign ret_addr      = upd_q.ret_addr;

endmodule

// File: tb/tb_supernova_branch_resolver.sv
// Bench for supernova_branch_resolver: directed table, corner sequences, random vs model.
module tb_supernova_branch_resolver;
  import supernova_bpu_pkg::*;

  localparam int XLEN     = 64;
  localparam int PQ_DEPTH = 16;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = 15;
  localparam int PW       = $clog2(PQ_DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pred_valid, pred_ready, pred_taken;
  logic [XLEN-1:0] pred_pc, pred_target;
  logic            res_valid, res_ready, res_taken, res_is_call, res_is_ret;
  logic [XLEN-1:0] res_pc, res_target;
  logic            update_en, update_taken, is_call, is_ret, redirect_valid;
  logic [XLEN-1:0] update_pc, update_target, ret_addr, redirect_pc;
  logic [CNT_W-1:0] mispredict_cnt;
  logic [PW-1:0]   pq_count;

  always #5 clk = ~clk;

  supernova_branch_resolver #(.XLEN(XLEN), .PQ_DEPTH(PQ_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_target(pred_target), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
    .res_target(res_target), .res_taken(res_taken),
    .res_is_call(res_is_call), .res_is_ret(res_is_ret),
    .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
    .update_taken(update_taken), .is_call(is_call), .is_ret(is_ret),
    .ret_addr(ret_addr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mispredict_cnt(mispredict_cnt), .pq_count(pq_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic pv, input logic [63:0] ppc, input logic [63:0] ptgt,
                       input logic ptk, input logic rv, input logic [63:0] rpc,
                       input logic [63:0] rtgt, input logic rtk, input logic rc, input logic rr);
    pred_valid = pv; pred_pc = ppc; pred_target = ptgt; pred_taken = ptk;
    res_valid = rv; res_pc = rpc; res_target = rtgt; res_taken = rtk;
    res_is_call = rc; res_is_ret = rr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic pv; logic [63:0] ppc; logic [63:0] ptgt; logic ptk;
    logic rv; logic [63:0] rpc; logic [63:0] rtgt; logic rtk; logic rc; logic rr;
    logic e_pr; logic e_rr; logic e_en; logic [63:0] e_tgt; logic [63:0] e_ret;
    logic e_rdv; logic [63:0] e_rdpc; int e_cnt; int e_pq;
  } vec_t;

  vec_t tbl [15];

  // ---------------- reference model ----------------
  pred_entry_t mq[$];
  bit          m_flush;
  int          m_cnt;
  logic        e_en, e_utk, e_call, e_ret, e_rdv;
  logic [63:0] e_upc, e_utgt, e_uret, e_rdpc;

  task automatic model_reset();
    mq.delete();
    m_flush = 0; m_cnt = 0;
    e_en = 0; e_utk = 0; e_call = 0; e_ret = 0; e_rdv = 0;
    e_upc = 0; e_utgt = 0; e_uret = 0; e_rdpc = 0;
  endtask

  task automatic model_cycle();
    logic epr, err, push, fire, mis;
    pred_entry_t h;
    #1;
    epr = !m_flush && (mq.size() < PQ_DEPTH);
    err = !m_flush && (mq.size() > 0);
    check("rnd.pred_ready", pred_ready, epr);
    check("rnd.res_ready", res_ready, err);
    push = pred_valid && epr;
    fire = res_valid && err;
    mis = 0;
    if (fire) begin
      h = mq.pop_front();
      mis = (h.pc != res_pc) || (h.taken != res_taken) || (res_taken && (h.target != res_target));
      e_upc = res_pc; e_utgt = res_target; e_utk = res_taken;
      e_call = res_is_call; e_ret = res_is_ret;
      e_uret = res_is_call ? res_pc + 64'd4 : 64'd0;
    end
    e_en = fire;
    e_rdv = mis;
    if (mis) begin
      e_rdpc = res_taken ? res_target : res_pc + 64'd4;
      mq.delete();
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (push) begin
      mq.push_back('{pc: pred_pc, target: pred_target, taken: pred_taken});
    end
    m_flush = mis;
    @(posedge clk);
    #1;
    check("rnd.update_en", update_en, e_en);
    check("rnd.update_pc", update_pc, e_upc);
    check("rnd.update_target", update_target, e_utgt);
    check("rnd.update_taken", update_taken, e_utk);
    check("rnd.is_call", is_call, e_call);
    check("rnd.is_ret", is_ret, e_ret);
    check("rnd.ret_addr", ret_addr, e_uret);
    check("rnd.redirect_valid", redirect_valid, e_rdv);
    check("rnd.redirect_pc", redirect_pc, e_rdpc);
    check("rnd.cnt", mispredict_cnt, m_cnt);
    check("rnd.pq_count", pq_count, mq.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pred_entry_t h;
    int sel;

    //          pv ppc        ptgt      ptk rv rpc        rtgt      rtk rc rr  pr rr en tgt      ret      rdv rdpc     cnt pq
    tbl[0]  = '{1, 64'h1000, 64'h2000, 1,  0, 0,         0,        0,  0, 0,  1, 0, 0, 0,       0,       0,  0,       0,  1};
    tbl[1]  = '{0, 0,        0,        0,  1, 64'h1000, 64'h2000, 1,  0, 0,  1, 1, 1, 64'h2000, 0,      0,  0,       0,  0};
    tbl[2]  = '{1, 64'h1000, 64'h1004, 0,  0, 0,         0,        0,  0, 0,  1, 0, 0, 64'h2000, 0,      0,  0,       0,  1};
    tbl[3]  = '{0, 0,        0,        0,  1, 64'h1000, 64'h3000, 1,  0, 0,  1, 1, 1, 64'h3000, 0,      1,  64'h3000, 1, 0};
    tbl[4]  = '{1, 64'h4000, 64'h5000, 1,  0, 0,         0,        0,  0, 0,  0, 0, 0, 64'h3000, 0,      0,  64'h3000, 1, 0};
    tbl[5]  = '{1, 64'h4000, 64'h8000, 1,  0, 0,         0,        0,  0, 0,  1, 0, 0, 64'h3000, 0,      0,  64'h3000, 1, 1};
    tbl[6]  = '{0, 0,        0,        0,  1, 64'h4000, 64'h8000, 1,  1, 0,  1, 1, 1, 64'h8000, 64'h4004, 0, 64'h3000, 1, 0};
    tbl[7]  = '{1, 64'h8010, 64'h4004, 1,  0, 0,         0,        0,  0, 0,  1, 0, 0, 64'h8000, 64'h4004, 0, 64'h3000, 1, 1};
    tbl[8]  = '{0, 0,        0,        0,  1, 64'h8010, 64'h4004, 1,  0, 1,  1, 1, 1, 64'h4004, 0,      0,  64'h3000, 1, 0};
    tbl[9]  = '{1, 64'h9000, 64'h9100, 1,  0, 0,         0,        0,  0, 0,  1, 0, 0, 64'h4004, 0,      0,  64'h3000, 1, 1};
    tbl[10] = '{1, 64'hA000, 64'hA100, 1,  1, 64'h9000, 64'h9200, 1,  0, 0,  1, 1, 1, 64'h9200, 0,      1,  64'h9200, 2, 0};
    tbl[11] = '{0, 0,        0,        0,  0, 0,         0,        0,  0, 0,  0, 0, 0, 64'h9200, 0,      0,  64'h9200, 2, 0};
    tbl[12] = '{1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 1, 0, 0, 0, 0, 0, 0,      1, 0, 0, 64'h9200, 0,      0,  64'h9200, 2, 1};
    tbl[13] = '{0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h10, 0, 0, 0,      1, 1, 1, 64'h10,   0,      1,  64'h0,    3, 0};
    tbl[14] = '{0, 0,        0,        0,  0, 0,         0,        0,  0, 0,  0, 0, 0, 64'h10,   0,      0,  64'h0,    3, 0};

    // Reset state
    idle();
    #1;
    check("reset.update_en", update_en, 0);
    check("reset.update_pc", update_pc, 0);
    check("reset.update_target", update_target, 0);
    check("reset.ret_addr", ret_addr, 0);
    check("reset.redirect_valid", redirect_valid, 0);
    check("reset.redirect_pc", redirect_pc, 0);
    check("reset.cnt", mispredict_cnt, 0);
    check("reset.pq_count", pq_count, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Directed table: correct, mispredict + flush cycle, call/ret, lost push, wrap
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].pv, tbl[i].ppc, tbl[i].ptgt, tbl[i].ptk, tbl[i].rv, tbl[i].rpc,
            tbl[i].rtgt, tbl[i].rtk, tbl[i].rc, tbl[i].rr);
      #1;
      check($sformatf("tbl%0d.pred_ready", i), pred_ready, tbl[i].e_pr);
      check($sformatf("tbl%0d.res_ready", i), res_ready, tbl[i].e_rr);
      tick();
      check($sformatf("tbl%0d.update_en", i), update_en, tbl[i].e_en);
      check($sformatf("tbl%0d.update_target", i), update_target, tbl[i].e_tgt);
      check($sformatf("tbl%0d.ret_addr", i), ret_addr, tbl[i].e_ret);
      check($sformatf("tbl%0d.redirect_valid", i), redirect_valid, tbl[i].e_rdv);
      check($sformatf("tbl%0d.redirect_pc", i), redirect_pc, tbl[i].e_rdpc);
      check($sformatf("tbl%0d.cnt", i), mispredict_cnt, tbl[i].e_cnt);
      check($sformatf("tbl%0d.pq_count", i), pq_count, tbl[i].e_pq);
    end

    // Full queue: push blocked even when a pop fires the same cycle
    for (int i = 0; i < PQ_DEPTH; i++) begin
      drive(1, 64'h100 * (i + 1), 64'h200, 1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    idle();
    #1;
    check("full.pq_count", pq_count, PQ_DEPTH);
    check("full.pred_ready", pred_ready, 0);
    drive(1, 64'hDEAD, 64'hBEEF, 1, 1, 64'h100, 64'h200, 1, 0, 0);
    #1;
    check("full_pop.pred_ready", pred_ready, 0);
    check("full_pop.res_ready", res_ready, 1);
    tick();
    check("full_pop.pq_count", pq_count, PQ_DEPTH - 1);
    check("full_pop.update_en", update_en, 1);
    check("full_pop.redirect_valid", redirect_valid, 0);
    for (int i = 1; i < PQ_DEPTH; i++) begin
      drive(0, 0, 0, 0, 1, 64'h100 * (i + 1), 64'h200, 1, 0, 0);
      tick();
    end
    idle();
    #1;
    check("drain.pq_count", pq_count, 0);
    check("drain.cnt", mispredict_cnt, 3);

    // Counter saturation
    for (int k = 1; k <= 13; k++) begin
      drive(1, 64'h500, 64'h600, 1, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 1, 64'h500, 64'h600, 0, 0, 0);
      tick();
      check($sformatf("sat%0d.cnt", k), mispredict_cnt, (3 + k > CNT_MAX) ? CNT_MAX : 3 + k);
      idle();
      tick();
    end

    // Asynchronous reset mid-queue
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'h700 + 64'h10 * i, 64'h900, 1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    idle();
    #1;
    check("prearst.pq_count", pq_count, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst.pq_count", pq_count, 0);
    check("arst.cnt", mispredict_cnt, 0);
    check("arst.update_pc", update_pc, 0);
    check("arst.update_target", update_target, 0);
    check("arst.redirect_pc", redirect_pc, 0);
    check("arst.update_en", update_en, 0);
    check("arst.redirect_valid", redirect_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Randomized run against the model
    model_reset();
    for (int c = 0; c < 800; c++) begin
      pred_valid  = ($urandom_range(0, 3) != 0);
      pred_pc     = {$urandom, $urandom} & ~64'h3;
      pred_target = {$urandom, $urandom} & ~64'h3;
      pred_taken  = $urandom_range(0, 1);
      res_valid   = ($urandom_range(0, 2) != 0);
      res_is_call = ($urandom_range(0, 3) == 0);
      res_is_ret  = ($urandom_range(0, 3) == 0);
      if (mq.size() > 0) begin
        h = mq[0];
        res_pc = h.pc; res_target = h.target; res_taken = h.taken;
        sel = $urandom_range(0, 9);
        if (sel == 0) res_pc = res_pc ^ 64'h4;
        if (sel == 1) res_taken = ~res_taken;
        if (sel == 2) res_target = res_target ^ 64'h40;
      end else begin
        res_pc = {$urandom, $urandom};
        res_target = {$urandom, $urandom};
        res_taken = $urandom_range(0, 1);
      end
      model_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
